// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a W-bit add through an external 4-bit adder, one nibble per clock,
// least-significant nibble first, and assembles the sum and final carry.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 carry_in,
  output logic                 ready,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 done
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  result_nx;
  logic          carry_q;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN:  if (idx == LAST) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder inputs are forced to zero outside RUN so the external adder sees a quiet bus.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    result_nx = result;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        result_nx[4*i +: 4] = add_sum;
        if (state_q == RUN) begin
          add_a = a_q[4*i +: 4];
          add_b = b_q[4*i +: 4];
        end
      end
    end
    if (state_q == RUN) add_cin = carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q       <= op_a;
          b_q       <= op_b;
          carry_q   <= carry_in;
          idx       <= '0;
          result    <= '0;
          carry_out <= 1'b0;
        end
        RUN: begin
          result  <= result_nx;
          carry_q <= add_cout;
          // idx saturates on the last nibble; the next accept rewinds it.
          if (idx != LAST) idx <= idx + 1'b1;
          else             carry_out <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of the nibble-serial adder controller against
// a plain-arithmetic reference, with a behavioural 4-bit adder closing the loop.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          carry_in = 1'b0;
  logic          ready, add_cin, add_cout, carry_out, done;
  logic [3:0]    add_a, add_b, add_sum;
  logic [W-1:0]  result;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned done_cnt = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .ready(ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .result(result), .carry_out(carry_out), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation; hold keeps start asserted, inject fires a stray start mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit hold, input bit inject, input string name);
    logic [W:0]  full;
    logic [31:0] m, part;
    int unsigned d0, waited;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    waited = 0;
    while (ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk({name, "_ready"}, 64'(ready), 64'd1);
    op_a = a; op_b = b; carry_in = cin; start = 1'b1;
    d0 = done_cnt;
    tick();
    if (!hold) start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom);
    for (int unsigned i = 0; i < N; i++) begin
      m    = (32'd1 << (4*i)) - 1;
      part = (32'(a) & m) + (32'(b) & m) + 32'(cin);
      chk({name, "_add_a"},   64'(add_a),   64'((a >> (4*i)) & 4'hF));
      chk({name, "_add_b"},   64'(add_b),   64'((b >> (4*i)) & 4'hF));
      chk({name, "_add_cin"}, 64'(add_cin), 64'((part >> (4*i)) & 1));
      chk({name, "_partial"}, 64'(result),  64'(32'(full) & m));
      chk({name, "_run_flags"}, 64'({ready, done, carry_out}), 64'd0);
      if (inject && i == 1) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'hAAAA; carry_in = 1'b1;
      end else if (inject && i == 2) begin
        start = 1'b0;
      end
      tick();
    end
    chk({name, "_done"},      64'(done),      64'd1);
    chk({name, "_result"},    64'(result),    64'(full[W-1:0]));
    chk({name, "_carry_out"}, 64'(carry_out), 64'(full[W]));
    chk({name, "_idle_bus"},  64'({add_a, add_b, add_cin}), 64'd0);
    chk({name, "_ready_lo"},  64'(ready), 64'd0);
    tick();
    chk({name, "_ready_back"}, 64'(ready), 64'd1);
    chk({name, "_done_once"},  64'(done_cnt - d0), 64'd1);
    chk({name, "_hold_res"},   64'(result), 64'(full[W-1:0]));
    chk({name, "_hold_co"},    64'(carry_out), 64'(full[W]));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned d0;
    #3;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_outs",  64'({done, carry_out, result, add_a, add_b, add_cin}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "zero");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "ripple");
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, "seq");
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, "ignore");

    // Abort mid-run with an asynchronous reset pulse.
    op_a = 16'h1234; op_b = 16'h1111; start = 1'b1;
    d0 = done_cnt;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_outs",  64'({done, carry_out, result, add_a, add_b, add_cin}), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 6; k++) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_result",  64'(result), 64'd0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, "after_rst");

    for (int unsigned k = 0; k < 20; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b0, 1'b0, "rand");
    end

    // Back-to-back with start held high.
    for (int unsigned k = 0; k < 4; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b1, 1'b0, "b2b");
    end
    start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
